// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - VGA timing bundle from sync generator to pattern generator
interface vga_sync_gen_if;
   logic       p_tick;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       frame_start;

   modport master (
      output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
   );

   modport slave (
      input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
   );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing generator, all outputs registered
module vga_sync_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int CLK_DIV   = 4,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   vga_sync_gen_if.master  vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DW      = $clog2(CLK_DIV);

   localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
   localparam logic [9:0]    H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0]    HS_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0]    HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]    VS_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0]    VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [DW-1:0] div_cnt;
   logic          div_wrap;
   logic          x_wrap;
   logic          frame_wrap;
   logic [9:0]    x_next;
   logic [9:0]    y_next;
   logic          hs_act;
   logic          vs_act;
   logic          vis_next;

   // Decode is taken from the next counter values so the registered syncs
   // and video_on line up with pixel_x/pixel_y after the same edge.
   always_comb begin
      div_wrap   = (div_cnt == DIV_MAX);
      x_wrap     = (vga.pixel_x == H_MAX);
      frame_wrap = x_wrap && (vga.pixel_y == V_MAX);
      x_next     = x_wrap ? 10'd0 : vga.pixel_x + 10'd1;
      y_next     = vga.pixel_y;
      if (x_wrap) begin
         y_next = (vga.pixel_y == V_MAX) ? 10'd0 : vga.pixel_y + 10'd1;
      end
      hs_act   = (x_next >= HS_FIRST) && (x_next <= HS_LAST);
      vs_act   = (y_next >= VS_FIRST) && (y_next <= VS_LAST);
      vis_next = (x_next < H_VIS) && (y_next < V_VIS);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt         <= '0;
         vga.p_tick      <= 1'b0;
         vga.pixel_x     <= 10'd0;
         vga.pixel_y     <= 10'd0;
         vga.video_on    <= 1'b0;
         vga.hsync       <= ~SYNC_POL;
         vga.vsync       <= ~SYNC_POL;
         vga.frame_start <= 1'b0;
      end else begin
         vga.p_tick      <= div_wrap;
         vga.frame_start <= div_wrap && frame_wrap;
         if (div_wrap) begin
            div_cnt      <= '0;
            vga.pixel_x  <= x_next;
            vga.pixel_y  <= y_next;
            vga.video_on <= vis_next;
            vga.hsync    <= hs_act ? SYNC_POL : ~SYNC_POL;
            vga.vsync    <= vs_act ? SYNC_POL : ~SYNC_POL;
         end else begin
            div_cnt      <= div_cnt + DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen (reduced timing)
module tb_vga_sync_gen;

   // Reduced geometry: 15 pixels x 8 lines, hsync on x 10..12, vsync on y 5..6
   localparam int CD = 4;
   localparam int HT = 15;
   localparam int VT = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   vga_sync_gen_if vif ();

   vga_sync_gen #(
      .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
      .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
      .CLK_DIV   (CD), .SYNC_POL (1'b0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .vga   (vif.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int fs_count, max_x, max_y, first_tick, first_hs_fall, first_vs_fall;
   int hs_low_line0, vs_low_frame0;
   logic hs_prev, vs_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_x"},  32'(vif.pixel_x), 0);
      check({tag, "_y"},  32'(vif.pixel_y), 0);
      check({tag, "_hs"}, 32'(vif.hsync), 1);
      check({tag, "_vs"}, 32'(vif.vsync), 1);
      check({tag, "_vo"}, 32'(vif.video_on), 0);
      check({tag, "_pt"}, 32'(vif.p_tick), 0);
      check({tag, "_fs"}, 32'(vif.frame_start), 0);
   endtask

   task automatic clear_stats();
      fs_count = 0; max_x = 0; max_y = 0;
      first_tick = -1; first_hs_fall = -1; first_vs_fall = -1;
      hs_low_line0 = 0; vs_low_frame0 = 0;
      hs_prev = 1'b1; vs_prev = 1'b1;
   endtask

   // n = number of posedges since reset release; sampled on the following negedge
   task automatic run(input int from, input int to);
      int t, ex, ey, ept, evo, ehs, evs, efs;
      for (int n = from; n <= to; n++) begin
         @(posedge clk);
         @(negedge clk);
         t   = n / CD;
         ex  = t % HT;
         ey  = (t / HT) % VT;
         ept = (n > 0 && n % CD == 0) ? 1 : 0;
         evo = (t > 0 && ex < 8 && ey < 4) ? 1 : 0;
         ehs = (ex >= 10 && ex <= 12) ? 0 : 1;
         evs = (ey >= 5 && ey <= 6) ? 0 : 1;
         efs = (ept == 1 && ex == 0 && ey == 0) ? 1 : 0;
         check("x",  32'(vif.pixel_x), ex);
         check("y",  32'(vif.pixel_y), ey);
         check("pt", 32'(vif.p_tick), ept);
         check("vo", 32'(vif.video_on), evo);
         check("hs", 32'(vif.hsync), ehs);
         check("vs", 32'(vif.vsync), evs);
         check("fs", 32'(vif.frame_start), efs);
         if (vif.frame_start === 1'b1) fs_count++;
         if (int'(vif.pixel_x) > max_x) max_x = int'(vif.pixel_x);
         if (int'(vif.pixel_y) > max_y) max_y = int'(vif.pixel_y);
         if (vif.p_tick === 1'b1 && first_tick < 0) first_tick = n;
         if (hs_prev === 1'b1 && vif.hsync === 1'b0 && first_hs_fall < 0) first_hs_fall = n;
         if (vs_prev === 1'b1 && vif.vsync === 1'b0 && first_vs_fall < 0) first_vs_fall = n;
         if (n <= HT * CD && vif.hsync === 1'b0) hs_low_line0++;
         if (n <= HT * VT * CD && vif.vsync === 1'b0) vs_low_frame0++;
         hs_prev = vif.hsync;
         vs_prev = vif.vsync;
      end
   endtask

   initial begin
      clear_stats();
      repeat (3) @(negedge clk);
      check_reset_state("por");

      reset = 1'b0;
      run(1, 1000);
      check("first_tick",    32'(first_tick), 4);
      check("hs_first_fall", 32'(first_hs_fall), 40);
      check("hs_low_clks",   32'(hs_low_line0), 12);
      check("vs_first_fall", 32'(first_vs_fall), 300);
      check("vs_low_clks",   32'(vs_low_frame0), 120);
      check("fs_count",      32'(fs_count), 2);
      check("max_x",         32'(max_x), 14);
      check("max_y",         32'(max_y), 7);

      // Reach y = 6 with hsync active (tick 340 -> x = 10, y = 6), then reset mid-sync
      run(1001, 1360);
      check("pre_rst_hs", 32'(vif.hsync), 0);
      check("pre_rst_vs", 32'(vif.vsync), 0);
      #2 reset = 1'b1;
      #1 check_reset_state("async");
      repeat (3) @(negedge clk);
      check_reset_state("held");

      reset = 1'b0;
      clear_stats();
      run(1, 400);
      check("re_first_tick",    32'(first_tick), 4);
      check("re_hs_first_fall", 32'(first_hs_fall), 40);
      check("re_vs_first_fall", 32'(first_vs_fall), 300);
      check("re_fs_count",      32'(fs_count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
